// File: rtl/bsg_manycore_store_responder.sv
// Remote-store endpoint for a memory or peripheral tile on the manycore network.
// Forward store packets are buffered, written to a local word memory port, and
// each completed store sends one credit packet back to its sender.
// Non-store packets are dropped and counted.
module bsg_manycore_store_responder #(
    parameter int x_cord_width_p   = 4,
    parameter int y_cord_width_p   = 4,
    parameter int data_width_p     = 32,
    parameter int addr_width_p     = 32,
    parameter int mem_addr_width_p = 12,
    parameter int in_fifo_els_p    = 2,
    parameter int ret_fifo_els_p   = 4,
    localparam int packet_width_lp =
        6 + 2*x_cord_width_p + 2*y_cord_width_p + data_width_p + addr_width_p,
    localparam int ret_packet_width_lp = 5 + x_cord_width_p + y_cord_width_p
) (
    input  logic                           clk_i,
    input  logic                           reset_ni,

    input  logic                           v_i,
    input  logic [packet_width_lp-1:0]     data_i,
    output logic                           ready_o,

    output logic                           mem_v_o,
    output logic [mem_addr_width_p-1:0]    mem_addr_o,
    output logic [data_width_p-1:0]        mem_data_o,
    output logic [data_width_p/8-1:0]      mem_mask_o,
    input  logic                           mem_yumi_i,

    output logic                           ret_v_o,
    output logic [ret_packet_width_lp-1:0] ret_data_o,
    input  logic                           ret_ready_i,

    output logic [15:0]                    store_count_o,
    output logic [15:0]                    unknown_count_o
);

    localparam int XW = x_cord_width_p;
    localparam int YW = y_cord_width_p;

    // Packet field offsets, LSB first: x_cord, y_cord, from_x, from_y, data, addr, op
    localparam int FromXLsb = XW + YW;
    localparam int FromYLsb = 2*XW + YW;
    localparam int DataLsb  = 2*XW + 2*YW;
    localparam int AddrLsb  = DataLsb + data_width_p;

    localparam logic [5:0] StoreOp = 6'd1;

    localparam int InPtrW  = (in_fifo_els_p > 1) ? $clog2(in_fifo_els_p) : 1;
    localparam int InCntW  = $clog2(in_fifo_els_p + 1);
    localparam int RetPtrW = (ret_fifo_els_p > 1) ? $clog2(ret_fifo_els_p) : 1;
    localparam int RetCntW = $clog2(ret_fifo_els_p + 1);

    localparam logic [InPtrW-1:0]  InLastPtr  = InPtrW'(in_fifo_els_p - 1);
    localparam logic [InCntW-1:0]  InFullCnt  = InCntW'(in_fifo_els_p);
    localparam logic [RetPtrW-1:0] RetLastPtr = RetPtrW'(ret_fifo_els_p - 1);
    localparam logic [RetCntW-1:0] RetFullCnt = RetCntW'(ret_fifo_els_p);

    // Input packet buffer
    logic [packet_width_lp-1:0] inMem_q [in_fifo_els_p];
    logic [InPtrW-1:0]          inRdPtr_q, inRdPtr_d;
    logic [InPtrW-1:0]          inWrPtr_q, inWrPtr_d;
    logic [InCntW-1:0]          inCount_q, inCount_d;

    // Pending return-packet buffer
    logic [ret_packet_width_lp-1:0] retMem_q [ret_fifo_els_p];
    logic [RetPtrW-1:0]             retRdPtr_q, retRdPtr_d;
    logic [RetPtrW-1:0]             retWrPtr_q, retWrPtr_d;
    logic [RetCntW-1:0]             retCount_q, retCount_d;

    logic [15:0] storeCount_q, storeCount_d;
    logic [15:0] unknownCount_q, unknownCount_d;

    logic [packet_width_lp-1:0]     headPkt;
    logic [5:0]                     headOp;
    logic [addr_width_p-1:0]        headAddr;
    logic [data_width_p-1:0]        headData;
    logic [XW-1:0]                  headFromX;
    logic [YW-1:0]                  headFromY;
    logic [ret_packet_width_lp-1:0] retPushData;
    logic                           headValid;
    logic                           headIsStore;
    logic                           retHasRoom;
    logic                           inPush;
    logic                           inPop;
    logic                           storeFire;
    logic                           unknownDrop;
    logic                           retPush;
    logic                           retPop;
    logic                           unusedHeadBits;

    // Decode the head of the input buffer and derive all handshakes.
    // Return-buffer room uses the registered count, so a pop this cycle
    // does not free a slot for a store issued in the same cycle.
    always_comb begin
        headPkt     = inMem_q[inRdPtr_q];
        headOp      = headPkt[packet_width_lp-1 -: 6];
        headAddr    = headPkt[AddrLsb +: addr_width_p];
        headData    = headPkt[DataLsb +: data_width_p];
        headFromX   = headPkt[FromXLsb +: XW];
        headFromY   = headPkt[FromYLsb +: YW];
        headValid   = (inCount_q != '0);
        headIsStore = (headOp == StoreOp);
        retHasRoom  = (retCount_q != RetFullCnt);

        ready_o     = (inCount_q != InFullCnt);
        inPush      = v_i & ready_o;

        mem_v_o     = headValid & headIsStore & retHasRoom;
        storeFire   = mem_v_o & mem_yumi_i;
        unknownDrop = headValid & ~headIsStore;
        inPop       = storeFire | unknownDrop;

        ret_v_o     = (retCount_q != '0);
        retPop      = ret_v_o & ret_ready_i;
        retPush     = storeFire;
        retPushData = {5'b0, headFromY, headFromX};
        ret_data_o  = retMem_q[retRdPtr_q];

        mem_addr_o  = headAddr[2 +: mem_addr_width_p];
        mem_data_o  = headData;
        mem_mask_o  = '1;

        store_count_o   = storeCount_q;
        unknown_count_o = unknownCount_q;
    end

    // Destination coordinates and unused address bits have no consumer here.
    assign unusedHeadBits = ^{headPkt[XW+YW-1:0], headAddr};

    // Next-state for both buffers' pointers/occupancy and the two counters.
    always_comb begin
        inRdPtr_d      = inRdPtr_q;
        inWrPtr_d      = inWrPtr_q;
        inCount_d      = inCount_q;
        retRdPtr_d     = retRdPtr_q;
        retWrPtr_d     = retWrPtr_q;
        retCount_d     = retCount_q;
        storeCount_d   = storeCount_q;
        unknownCount_d = unknownCount_q;

        if (inPop) begin
            inRdPtr_d = (inRdPtr_q == InLastPtr) ? '0 : inRdPtr_q + InPtrW'(1);
        end
        if (inPush) begin
            inWrPtr_d = (inWrPtr_q == InLastPtr) ? '0 : inWrPtr_q + InPtrW'(1);
        end
        case ({inPush, inPop})
            2'b10:   inCount_d = inCount_q + InCntW'(1);
            2'b01:   inCount_d = inCount_q - InCntW'(1);
            default: inCount_d = inCount_q;
        endcase

        if (retPop) begin
            retRdPtr_d = (retRdPtr_q == RetLastPtr) ? '0 : retRdPtr_q + RetPtrW'(1);
        end
        if (retPush) begin
            retWrPtr_d = (retWrPtr_q == RetLastPtr) ? '0 : retWrPtr_q + RetPtrW'(1);
        end
        case ({retPush, retPop})
            2'b10:   retCount_d = retCount_q + RetCntW'(1);
            2'b01:   retCount_d = retCount_q - RetCntW'(1);
            default: retCount_d = retCount_q;
        endcase

        if (storeFire) begin
            storeCount_d = storeCount_q + 16'd1;
        end
        if (unknownDrop && (unknownCount_q != 16'hFFFF)) begin
            unknownCount_d = unknownCount_q + 16'd1;
        end
    end

    // Control state; reset discards everything buffered.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            inRdPtr_q      <= '0;
            inWrPtr_q      <= '0;
            inCount_q      <= '0;
            retRdPtr_q     <= '0;
            retWrPtr_q     <= '0;
            retCount_q     <= '0;
            storeCount_q   <= '0;
            unknownCount_q <= '0;
        end else begin
            inRdPtr_q      <= inRdPtr_d;
            inWrPtr_q      <= inWrPtr_d;
            inCount_q      <= inCount_d;
            retRdPtr_q     <= retRdPtr_d;
            retWrPtr_q     <= retWrPtr_d;
            retCount_q     <= retCount_d;
            storeCount_q   <= storeCount_d;
            unknownCount_q <= unknownCount_d;
        end
    end

    // Buffer storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (inPush) begin
            inMem_q[inWrPtr_q] <= data_i;
        end
        if (retPush) begin
            retMem_q[retWrPtr_q] <= retPushData;
        end
    end

endmodule

// File: tb/tb_bsg_manycore_store_responder.sv
// Self-checking bench for bsg_manycore_store_responder: a queue-based model
// predicts every output each cycle; directed sections add literal expectations.
module tb_bsg_manycore_store_responder;

    localparam int XW      = 4;
    localparam int YW      = 4;
    localparam int DW      = 32;
    localparam int AW      = 32;
    localparam int MAW     = 12;
    localparam int IN_ELS  = 2;
    localparam int RET_ELS = 4;
    localparam int PW      = 6 + 2*XW + 2*YW + DW + AW;
    localparam int RW      = 5 + XW + YW;

    typedef struct {
        logic [5:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [YW-1:0] fy;
        logic [XW-1:0] fx;
        logic [YW-1:0] y;
        logic [XW-1:0] x;
    } pkt_t;

    logic            clk_i = 1'b0;
    logic            reset_ni;
    logic            v_i;
    logic [PW-1:0]   data_i;
    logic            ready_o;
    logic            mem_v_o;
    logic [MAW-1:0]  mem_addr_o;
    logic [DW-1:0]   mem_data_o;
    logic [DW/8-1:0] mem_mask_o;
    logic            mem_yumi_i;
    logic            ret_v_o;
    logic [RW-1:0]   ret_data_o;
    logic            ret_ready_i;
    logic [15:0]     store_count_o;
    logic [15:0]     unknown_count_o;

    pkt_t          inQ[$];
    logic [RW-1:0] retQ[$];
    logic [15:0]   mStore;
    logic [15:0]   mUnknown;
    pkt_t          curPkt;

    int checks = 0;
    int errors = 0;
    int memFires = 0;
    int retPops = 0;
    int acceptedStores = 0;
    int sent;

    always #5 clk_i = ~clk_i;

    bsg_manycore_store_responder #(
        .x_cord_width_p(XW), .y_cord_width_p(YW), .data_width_p(DW),
        .addr_width_p(AW), .mem_addr_width_p(MAW),
        .in_fifo_els_p(IN_ELS), .ret_fifo_els_p(RET_ELS)
    ) dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
        .mem_v_o(mem_v_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_mask_o(mem_mask_o), .mem_yumi_i(mem_yumi_i),
        .ret_v_o(ret_v_o), .ret_data_o(ret_data_o), .ret_ready_i(ret_ready_i),
        .store_count_o(store_count_o), .unknown_count_o(unknown_count_o)
    );

    function automatic logic [PW-1:0] packPkt(input pkt_t p);
        return {p.op, p.addr, p.data, p.fy, p.fx, p.y, p.x};
    endfunction

    function automatic pkt_t makePkt(input logic [5:0] op, input logic [AW-1:0] addr,
                                     input logic [DW-1:0] data, input int fx, input int fy);
        pkt_t p;
        p.op   = op;
        p.addr = addr;
        p.data = data;
        p.fx   = XW'(fx);
        p.fy   = YW'(fy);
        p.x    = XW'($urandom);
        p.y    = YW'($urandom);
        return p;
    endfunction

    function automatic logic [RW-1:0] retOf(input pkt_t p);
        return {5'b0, p.fy, p.fx};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drivePkt(input pkt_t p);
        curPkt = p;
        data_i = packPkt(p);
        v_i    = 1'b1;
    endtask

    task automatic modelReset();
        inQ.delete();
        retQ.delete();
        mStore   = 16'd0;
        mUnknown = 16'd0;
    endtask

    // Compare every meaningful DUT output against the model's prediction.
    task automatic checkOutput();
        logic expMemV;
        expMemV = (inQ.size() > 0) && (inQ[0].op == 6'd1) && (retQ.size() < RET_ELS);
        check("ready_o", ready_o, inQ.size() < IN_ELS);
        check("mem_v_o", mem_v_o, expMemV);
        if (expMemV) begin
            check("mem_addr_o", mem_addr_o, inQ[0].addr[2 +: MAW]);
            check("mem_data_o", mem_data_o, inQ[0].data);
            check("mem_mask_o", mem_mask_o, {(DW/8){1'b1}});
        end
        check("ret_v_o", ret_v_o, retQ.size() > 0);
        if (retQ.size() > 0) begin
            check("ret_data_o", ret_data_o, retQ[0]);
        end
        check("store_count_o", store_count_o, mStore);
        check("unknown_count_o", unknown_count_o, mUnknown);
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic modelStep();
        logic expReady, expMemV, headUnk;
        pkt_t h;
        if (mem_v_o && mem_yumi_i) memFires++;
        if (ret_v_o && ret_ready_i) retPops++;
        if (!reset_ni) return;
        expReady = inQ.size() < IN_ELS;
        expMemV  = (inQ.size() > 0) && (inQ[0].op == 6'd1) && (retQ.size() < RET_ELS);
        headUnk  = (inQ.size() > 0) && (inQ[0].op != 6'd1);
        if ((retQ.size() > 0) && ret_ready_i) void'(retQ.pop_front());
        if (expMemV && mem_yumi_i) begin
            h = inQ.pop_front();
            retQ.push_back(retOf(h));
            mStore++;
        end else if (headUnk) begin
            void'(inQ.pop_front());
            if (mUnknown != 16'hFFFF) mUnknown++;
        end
        if (v_i && expReady) begin
            inQ.push_back(curPkt);
            if (curPkt.op == 6'd1) acceptedStores++;
        end
    endtask

    task automatic cycle();
        #1;
        checkOutput();
        modelStep();
        @(negedge clk_i);
        v_i = 1'b0;
    endtask

    task automatic applyStimulus();
        logic [5:0] op;
        op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'd1;
        if ($urandom_range(0, 3) != 0) drivePkt(makePkt(op, $urandom, $urandom, $urandom, $urandom));
        mem_yumi_i  = $urandom_range(0, 1) == 1;
        ret_ready_i = $urandom_range(0, 1) == 1;
    endtask

    initial begin
        reset_ni    = 1'b0;
        v_i         = 1'b0;
        data_i      = '0;
        mem_yumi_i  = 1'b0;
        ret_ready_i = 1'b0;
        curPkt      = makePkt(6'd0, 0, 0, 0, 0);
        modelReset();

        @(negedge clk_i);
        #1;
        check("reset ready_o", ready_o, 1'b1);
        check("reset mem_v_o", mem_v_o, 1'b0);
        check("reset ret_v_o", ret_v_o, 1'b0);
        check("reset store_count", store_count_o, 16'd0);
        check("reset unknown_count", unknown_count_o, 16'd0);
        @(negedge clk_i);
        reset_ni = 1'b1;
        cycle();

        // Single store, latency and field mapping
        mem_yumi_i  = 1'b1;
        ret_ready_i = 1'b1;
        drivePkt(makePkt(6'd1, 32'h40, 32'hDEADBEEF, 2, 3));
        cycle();
        #1;
        check("t1 mem_v_o", mem_v_o, 1'b1);
        check("t1 mem_addr_o", mem_addr_o, 12'h010);
        check("t1 mem_data_o", mem_data_o, 32'hDEADBEEF);
        check("t1 ret_v_early", ret_v_o, 1'b0);
        cycle();
        #1;
        check("t1 ret_v_o", ret_v_o, 1'b1);
        check("t1 ret_data_o", ret_data_o, 13'h032);
        check("t1 store_count", store_count_o, 16'd1);
        cycle();
        cycle();

        // Backpressure chain with 10 stores
        ret_ready_i = 1'b0;
        mem_yumi_i  = 1'b1;
        memFires = 0;
        retPops  = 0;
        sent     = 0;
        for (int c = 0; c < 20; c++) begin
            if (sent < 10) begin
                drivePkt(makePkt(6'd1, 32'h100 + 32'(4*sent), 32'h11111111 * 32'(sent + 1), sent, sent + 5));
                if (ready_o) sent++;
            end
            cycle();
        end
        check("t2 mem writes while blocked", memFires, 4);
        check("t2 ready_o low", ready_o, 1'b0);
        check("t2 accepted while blocked", sent, 6);

        // Full return buffer popped this cycle: no credit until next cycle
        ret_ready_i = 1'b1;
        #1;
        check("t6 mem_v_o same cycle", mem_v_o, 1'b0);
        cycle();
        #1;
        check("t6 mem_v_o next cycle", mem_v_o, 1'b1);
        for (int c = 0; c < 60; c++) begin
            if (sent < 10) begin
                drivePkt(makePkt(6'd1, 32'h100 + 32'(4*sent), 32'h11111111 * 32'(sent + 1), sent, sent + 5));
                if (ready_o) sent++;
            end
            cycle();
        end
        check("t2 total mem writes", memFires, 10);
        check("t2 total returns", retPops, 10);
        check("t2 store_count", store_count_o, 16'd11);

        // Unknown op between two stores
        memFires = 0;
        retPops  = 0;
        drivePkt(makePkt(6'd1, 32'h200, 32'hA5A5A5A5, 7, 1));
        cycle();
        drivePkt(makePkt(6'd2, 32'h204, 32'h5A5A5A5A, 9, 9));
        cycle();
        drivePkt(makePkt(6'd1, 32'h208, 32'h12345678, 1, 7));
        cycle();
        for (int c = 0; c < 6; c++) cycle();
        check("t3 unknown_count", unknown_count_o, 16'd1);
        check("t3 mem writes", memFires, 2);
        check("t3 returns", retPops, 2);
        check("t3 store_count", store_count_o, 16'd13);

        // Randomized traffic
        retPops = 0;
        acceptedStores = 0;
        for (int c = 0; c < 30000 && acceptedStores < 1000; c++) begin
            applyStimulus();
            cycle();
        end
        check("t4 stores accepted in budget", acceptedStores >= 1000, 1'b1);
        mem_yumi_i  = 1'b1;
        ret_ready_i = 1'b1;
        for (int c = 0; c < 40; c++) cycle();
        check("t4 drained ret_v_o", ret_v_o, 1'b0);
        check("t4 returns equal stores", retPops, acceptedStores);

        // Asynchronous reset with pending input and return entries
        ret_ready_i = 1'b0;
        mem_yumi_i  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drivePkt(makePkt(6'd1, 32'h300 + 32'(4*i), $urandom, i, i));
            cycle();
        end
        cycle();
        mem_yumi_i = 1'b0;
        for (int i = 3; i < 5; i++) begin
            drivePkt(makePkt(6'd1, 32'h300 + 32'(4*i), $urandom, i, i));
            cycle();
        end
        cycle();
        check("t5 pending ready_o", ready_o, 1'b0);
        check("t5 pending ret_v_o", ret_v_o, 1'b1);
        #2;
        reset_ni = 1'b0;
        modelReset();
        #1;
        check("t5 async ready_o", ready_o, 1'b1);
        check("t5 async mem_v_o", mem_v_o, 1'b0);
        check("t5 async ret_v_o", ret_v_o, 1'b0);
        check("t5 async store_count", store_count_o, 16'd0);
        check("t5 async unknown_count", unknown_count_o, 16'd0);
        @(negedge clk_i);
        cycle();
        reset_ni    = 1'b1;
        mem_yumi_i  = 1'b1;
        ret_ready_i = 1'b1;
        cycle();
        drivePkt(makePkt(6'd1, 32'h3FC, 32'hCAFEF00D, 5, 6));
        cycle();
        #1;
        check("t5 post-reset mem_addr_o", mem_addr_o, 12'h0FF);
        for (int c = 0; c < 4; c++) cycle();
        check("t5 post-reset store_count", store_count_o, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
